// File: rtl/xgmii_tx_fault_sequencer.sv
// XGMII transmit stream selector: passes MAC data, idles, or Remote Fault ordered sets.
// Mode changes only on frame boundaries; fault exit is delayed by a hold counter.
module xgmii_tx_fault_sequencer #(
    parameter int FAULT_HOLD_CYCLES = 128
) (
    input  logic        clk_xgmii_tx,
    input  logic        reset_xgmii_tx,
    input  logic        ctrl_tx_enable_ctx,
    input  logic        status_local_fault_ctx,
    input  logic        status_remote_fault_ctx,
    input  logic [63:0] txd_in,
    input  logic [7:0]  txc_in,
    output logic [63:0] xgmii_txd,
    output logic [7:0]  xgmii_txc,
    output logic [1:0]  tx_mode,
    output logic        tx_frame_drop
);

    localparam int CW = $clog2(FAULT_HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD    = CW'(FAULT_HOLD_CYCLES);
    localparam logic [CW-1:0] HOLD_M1 = CW'(FAULT_HOLD_CYCLES - 1);
    localparam logic [63:0] IDLE_D = 64'h0707070707070707;
    localparam logic [63:0] RF_D   = 64'h0200009C0200009C;

    typedef enum logic [1:0] {
        MODE_NORMAL  = 2'd0,
        MODE_IDLE    = 2'd1,
        MODE_SEND_RF = 2'd2
    } mode_t;

    mode_t          mode_r, mode_next_s, req_mode_s;
    logic           in_frame_r, in_frame_next_s;
    logic           start_s, later_term_s, boundary_s;
    logic [7:0]     term_v_s;
    logic [CW-1:0]  lf_cnt_r, rf_cnt_r;
    logic           lf_held_r, rf_held_r, lf_held_s, rf_held_s;

    // Character decode, frame tracking and requested-mode selection
    always_comb begin
        term_v_s = 8'h00;
        for (int k = 0; k < 8; k++) begin
            term_v_s[k] = txc_in[k] && (txd_in[8*k +: 8] == 8'hFD);
        end
        start_s = (txc_in[0] && (txd_in[7:0] == 8'hFB)) ||
                  (txc_in[4] && (txd_in[39:32] == 8'hFB));
        if (txc_in[0] && (txd_in[7:0] == 8'hFB)) begin
            later_term_s = |term_v_s[7:1];
        end else begin
            later_term_s = |term_v_s[7:5];
        end
        if (start_s && !later_term_s) begin
            in_frame_next_s = 1'b1;
        end else if (|term_v_s) begin
            in_frame_next_s = 1'b0;
        end else begin
            in_frame_next_s = in_frame_r;
        end
        boundary_s = !in_frame_r && !start_s;
        // A live status counts as held immediately; the register covers the hold tail
        lf_held_s = status_local_fault_ctx || lf_held_r;
        rf_held_s = status_remote_fault_ctx || rf_held_r;
        if (lf_held_s) begin
            req_mode_s = MODE_SEND_RF;
        end else if (rf_held_s || !ctrl_tx_enable_ctx) begin
            req_mode_s = MODE_IDLE;
        end else begin
            req_mode_s = MODE_NORMAL;
        end
        if (boundary_s) begin
            mode_next_s = req_mode_s;
        end else begin
            mode_next_s = mode_r;
        end
    end

    // Mode state register
    always_ff @(posedge clk_xgmii_tx) begin
        if (reset_xgmii_tx) begin
            mode_r <= MODE_IDLE;
        end else begin
            mode_r <= mode_next_s;
        end
    end

    // Frame tracking and fault hysteresis counters
    always_ff @(posedge clk_xgmii_tx) begin
        if (reset_xgmii_tx) begin
            in_frame_r <= 1'b0;
            lf_cnt_r   <= '0;
            rf_cnt_r   <= '0;
            lf_held_r  <= 1'b0;
            rf_held_r  <= 1'b0;
        end else begin
            in_frame_r <= in_frame_next_s;
            if (status_local_fault_ctx) begin
                lf_cnt_r  <= '0;
                lf_held_r <= 1'b1;
            end else begin
                lf_cnt_r  <= (lf_cnt_r == HOLD) ? HOLD : lf_cnt_r + 1'b1;
                lf_held_r <= lf_held_r && (lf_cnt_r < HOLD_M1);
            end
            if (status_remote_fault_ctx) begin
                rf_cnt_r  <= '0;
                rf_held_r <= 1'b1;
            end else begin
                rf_cnt_r  <= (rf_cnt_r == HOLD) ? HOLD : rf_cnt_r + 1'b1;
                rf_held_r <= rf_held_r && (rf_cnt_r < HOLD_M1);
            end
        end
    end

    // Registered output word, mode and drop pulse
    always_ff @(posedge clk_xgmii_tx) begin
        if (reset_xgmii_tx) begin
            xgmii_txd     <= IDLE_D;
            xgmii_txc     <= 8'hFF;
            tx_mode       <= 2'd1;
            tx_frame_drop <= 1'b0;
        end else begin
            case (mode_next_s)
                MODE_NORMAL: begin
                    xgmii_txd <= txd_in;
                    xgmii_txc <= txc_in;
                end
                MODE_SEND_RF: begin
                    xgmii_txd <= RF_D;
                    xgmii_txc <= 8'h11;
                end
                default: begin
                    xgmii_txd <= IDLE_D;
                    xgmii_txc <= 8'hFF;
                end
            endcase
            tx_mode       <= mode_next_s;
            tx_frame_drop <= start_s && (mode_next_s != MODE_NORMAL);
        end
    end

endmodule

// File: tb/tb_xgmii_tx_fault_sequencer.sv
// Directed bench for xgmii_tx_fault_sequencer with a lane-scanning reference model.
module tb_xgmii_tx_fault_sequencer;

    localparam int HOLD = 128;
    localparam logic [63:0] IDLE_D = 64'h0707070707070707;
    localparam logic [63:0] RF_D   = 64'h0200009C0200009C;
    localparam logic [63:0] SOF_D  = 64'hD5555555555555FB;
    localparam logic [63:0] TERM_D = 64'h07070707FD112233;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        lf = 1'b0;
    logic        rf = 1'b0;
    logic [63:0] txd_in = IDLE_D;
    logic [7:0]  txc_in = 8'hFF;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic [1:0]  tx_mode;
    logic        tx_frame_drop;

    int tests = 0;
    int fails = 0;

    xgmii_tx_fault_sequencer #(.FAULT_HOLD_CYCLES(HOLD)) dut (
        .clk_xgmii_tx(clk),
        .reset_xgmii_tx(rst),
        .ctrl_tx_enable_ctx(en),
        .status_local_fault_ctx(lf),
        .status_remote_fault_ctx(rf),
        .txd_in(txd_in),
        .txc_in(txc_in),
        .xgmii_txd(xgmii_txd),
        .xgmii_txc(xgmii_txc),
        .tx_mode(tx_mode),
        .tx_frame_drop(tx_frame_drop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  mode;
        logic [63:0] txd;
        logic [7:0]  txc;
        logic        drop;
        logic        in_frame;
        logic        lf_seen;
        logic        rf_seen;
        logic [31:0] lf_run;
        logic [31:0] rf_run;
    } mstate_t;

    mstate_t ms;
    logic    chk_en = 1'b0;

    // Reference model: a fault counts while active or within HOLD clear cycles of its last sighting
    function automatic mstate_t model_step(input mstate_t s, input logic r, input logic e,
                                           input logic l, input logic f,
                                           input logic [63:0] d, input logic [7:0] c);
        mstate_t n = s;
        logic has_start, lf_h, rf_h;
        logic [1:0] req;
        if (r) begin
            n = '0;
            n.mode = 2'd1;
            n.txd  = IDLE_D;
            n.txc  = 8'hFF;
            return n;
        end
        has_start = (c[0] && d[7:0] == 8'hFB) || (c[4] && d[39:32] == 8'hFB);
        lf_h = l || (s.lf_seen && s.lf_run < HOLD);
        rf_h = f || (s.rf_seen && s.rf_run < HOLD);
        if (lf_h) req = 2'd2;
        else if (rf_h || !e) req = 2'd1;
        else req = 2'd0;
        if (!s.in_frame && !has_start) n.mode = req;
        if (n.mode == 2'd0) begin
            n.txd = d; n.txc = c;
        end else if (n.mode == 2'd2) begin
            n.txd = RF_D; n.txc = 8'h11;
        end else begin
            n.txd = IDLE_D; n.txc = 8'hFF;
        end
        n.drop = has_start && (n.mode != 2'd0);
        for (int k = 0; k < 8; k++) begin
            if (c[k] && d[8*k +: 8] == 8'hFB && (k == 0 || k == 4)) n.in_frame = 1'b1;
            else if (c[k] && d[8*k +: 8] == 8'hFD) n.in_frame = 1'b0;
        end
        if (l) begin n.lf_seen = 1'b1; n.lf_run = 32'd0; end
        else if (s.lf_run < 32'd100000) n.lf_run = s.lf_run + 32'd1;
        if (f) begin n.rf_seen = 1'b1; n.rf_run = 32'd0; end
        else if (s.rf_run < 32'd100000) n.rf_run = s.rf_run + 32'd1;
        return n;
    endfunction

    always @(posedge clk) begin
        ms <= model_step(ms, rst, en, lf, rf, txd_in, txc_in);
        if (rst) chk_en <= 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_txd", xgmii_txd, ms.txd);
            chk("model_txc", {56'd0, xgmii_txc}, {56'd0, ms.txc});
            chk("model_mode", {62'd0, tx_mode}, {62'd0, ms.mode});
            chk("model_drop", {63'd0, tx_frame_drop}, {63'd0, ms.drop});
        end
    end

    task automatic step(input logic [63:0] d, input logic [7:0] c);
        txd_in = d;
        txc_in = c;
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [63:0] d, input logic [7:0] c,
                       input logic [1:0] m, input logic dr);
        chk({name, "_txd"}, xgmii_txd, d);
        chk({name, "_txc"}, {56'd0, xgmii_txc}, {56'd0, c});
        chk({name, "_mode"}, {62'd0, tx_mode}, {62'd0, m});
        chk({name, "_drop"}, {63'd0, tx_frame_drop}, {63'd0, dr});
    endtask

    initial begin
        rst = 1'b1;
        step(IDLE_D, 8'hFF);
        step(IDLE_D, 8'hFF);
        lit("reset", IDLE_D, 8'hFF, 2'd1, 1'b0);
        rst = 1'b0; en = 1'b1;
        step(IDLE_D, 8'hFF);
        lit("enable", IDLE_D, 8'hFF, 2'd0, 1'b0);
        step(SOF_D, 8'h01);
        lit("sof_pass", SOF_D, 8'h01, 2'd0, 1'b0);
        step(64'h1122334455667701, 8'h00);
        lf = 1'b1;
        step(64'h1122334455667702, 8'h00);
        lit("lf_midframe", 64'h1122334455667702, 8'h00, 2'd0, 1'b0);
        step(TERM_D, 8'hF8);
        lit("lf_term", TERM_D, 8'hF8, 2'd0, 1'b0);
        step(IDLE_D, 8'hFF);
        lit("lf_rf", RF_D, 8'h11, 2'd2, 1'b0);

        lf = 1'b0;
        for (int i = 0; i < 100; i++) step(IDLE_D, 8'hFF);
        lit("hold_100", RF_D, 8'h11, 2'd2, 1'b0);
        lf = 1'b1;
        step(IDLE_D, 8'hFF);
        lf = 1'b0;
        for (int i = 0; i < HOLD; i++) step(IDLE_D, 8'hFF);
        lit("hold_last", RF_D, 8'h11, 2'd2, 1'b0);
        step(IDLE_D, 8'hFF);
        lit("hold_exit", IDLE_D, 8'hFF, 2'd0, 1'b0);

        rf = 1'b1;
        step(IDLE_D, 8'hFF);
        lit("rf_idle", IDLE_D, 8'hFF, 2'd1, 1'b0);
        lf = 1'b1;
        step(IDLE_D, 8'hFF);
        lit("lf_rf_both", RF_D, 8'h11, 2'd2, 1'b0);
        step(SOF_D, 8'h01);
        lit("rf_drop", RF_D, 8'h11, 2'd2, 1'b1);
        lf = 1'b0; rf = 1'b0;
        for (int i = 0; i < 140; i++) step(64'hA5A5A5A5A5A5A500 + 64'(i), 8'h00);
        lit("long_frame", RF_D, 8'h11, 2'd2, 1'b0);
        step(TERM_D, 8'hF8);
        lit("long_term", RF_D, 8'h11, 2'd2, 1'b0);
        step(IDLE_D, 8'hFF);
        lit("after_term", IDLE_D, 8'hFF, 2'd0, 1'b0);

        step(64'h07FD0504030201FB, 8'hC1);
        lit("short_frame", 64'h07FD0504030201FB, 8'hC1, 2'd0, 1'b0);
        step(IDLE_D, 8'hFF);

        en = 1'b0;
        step(IDLE_D, 8'hFF);
        lit("disable", IDLE_D, 8'hFF, 2'd1, 1'b0);
        step(64'h555555FB07070707, 8'h1F);
        lit("lane4_drop", IDLE_D, 8'hFF, 2'd1, 1'b1);
        step(TERM_D, 8'hF8);
        en = 1'b1;
        step(IDLE_D, 8'hFF);
        lit("reenable", IDLE_D, 8'hFF, 2'd0, 1'b0);

        step(SOF_D, 8'h01);
        step(64'h0102030405060708, 8'h00);
        rst = 1'b1;
        step(64'h1112131415161718, 8'h00);
        lit("reset_mid", IDLE_D, 8'hFF, 2'd1, 1'b0);
        rst = 1'b0;
        step(64'h2122232425262728, 8'h00);
        lit("post_reset", 64'h2122232425262728, 8'h00, 2'd0, 1'b0);
        step(TERM_D, 8'hF8);
        for (int i = 0; i < 3; i++) step(IDLE_D, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
